// File: rtl/mac_array_accum.sv
// mac_array_accum: N_CH-channel multiply-accumulate array for the dense output layer.
// A shared activation is multiplied by per-channel signed weights into a product
// register, then summed with saturation into per-channel accumulators. After DEPTH
// accepted samples the sums are offered on a valid/ready handshake.
module mac_array_accum #(
    parameter int N_CH    = 10,
    parameter int IN_W    = 8,
    parameter int WT_W    = 8,
    parameter int ACC_W   = 24,
    parameter int DEPTH   = 128,
    parameter int ACT_SGN = 0,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         act_in,
    input  logic [N_CH*WT_W-1:0]    wt_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_CH*ACC_W-1:0]   sum_out,
    output logic [N_CH-1:0]         ovf,
    output logic [CNT_W-1:0]        count
);

    localparam int P_W = IN_W + WT_W + 1;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               p_valid_q, p_valid_d;
    logic [P_W-1:0]     prod_q [N_CH];
    logic [P_W-1:0]     prod_d [N_CH];
    logic [ACC_W-1:0]   acc_q  [N_CH];
    logic [ACC_W-1:0]   acc_d  [N_CH];
    logic [N_CH-1:0]    ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W:0]     sat_s  [N_CH];
    logic               accept_s;

    // Activation extension (zero or sign) times sign-extended weight, at product width.
    function automatic logic [P_W-1:0] mul_ext(input logic [IN_W-1:0] a,
                                               input logic [WT_W-1:0] w);
        logic signed [P_W-1:0] a_x;
        logic signed [P_W-1:0] w_x;
        if (ACT_SGN != 0) begin
            a_x = {{(P_W-IN_W){a[IN_W-1]}}, a};
        end else begin
            a_x = {{(P_W-IN_W){1'b0}}, a};
        end
        w_x = {{(P_W-WT_W){w[WT_W-1]}}, w};
        return a_x * w_x;
    endfunction

    // Saturating add; returns {clamped, result}.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [P_W-1:0] p);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {{(ACC_W+1-P_W){p[P_W-1]}}, p};
        if (s[ACC_W] != s[ACC_W-1]) begin
            if (s[ACC_W]) begin
                return {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                return {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            return {1'b0, s[ACC_W-1:0]};
        end
    endfunction

    // Next-state, product capture, saturating accumulation and flush override.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        p_valid_d   = 1'b0;
        prod_d      = prod_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        accept_s    = in_valid & in_ready_q;

        for (int m = 0; m < N_CH; m++) begin
            sat_s[m] = sat_add(acc_q[m], prod_q[m]);
            if (p_valid_q) begin
                acc_d[m] = sat_s[m][ACC_W-1:0];
                ovf_d[m] = ovf_q[m] | sat_s[m][ACC_W];
            end else begin
                acc_d[m] = acc_q[m];
            end
        end

        case (state_q)
            ST_ACCUM: begin
                if (accept_s) begin
                    for (int m = 0; m < N_CH; m++) begin
                        prod_d[m] = mul_ext(act_in, wt_in[m*WT_W +: WT_W]);
                    end
                    p_valid_d = 1'b1;
                    count_d   = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(DEPTH - 1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_ACCUM;
                    count_d = '0;
                    ovf_d   = '0;
                    for (int m = 0; m < N_CH; m++) begin
                        acc_d[m] = '0;
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase

        if (flush) begin
            state_d   = ST_ACCUM;
            count_d   = '0;
            p_valid_d = 1'b0;
            ovf_d     = '0;
            for (int m = 0; m < N_CH; m++) begin
                prod_d[m] = '0;
                acc_d[m]  = '0;
            end
        end else begin
            state_d = state_d;
        end

        in_ready_d  = (state_d == ST_ACCUM);
        out_valid_d = (state_d == ST_DONE);
    end

    // State, pipeline and accumulator registers with asynchronous clear.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= ST_ACCUM;
            count_q     <= '0;
            p_valid_q   <= 1'b0;
            ovf_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            for (int m = 0; m < N_CH; m++) begin
                prod_q[m] <= '0;
                acc_q[m]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            p_valid_q   <= p_valid_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_sum
        assign sum_out[g*ACC_W +: ACC_W] = acc_q[g];
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
    assign count     = count_q;

endmodule

// File: tb/tb_mac_array_accum.sv
// Bench for mac_array_accum: an unsigned and a signed-activation instance share one
// stimulus stream; a queue-based reference model predicts handshake and sums.
module tb_mac_array_accum;

    localparam int N_CH  = 2;
    localparam int IN_W  = 8;
    localparam int WT_W  = 8;
    localparam int ACC_W = 16;
    localparam int DEPTH = 3;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  clk = 1'b0;
    logic                  clr;
    logic                  flush;
    logic                  in_valid;
    logic                  out_ready;
    logic [IN_W-1:0]       act_in;
    logic [N_CH*WT_W-1:0]  wt_in;

    logic                  in_ready_u, out_valid_u, in_ready_s, out_valid_s;
    logic [N_CH*ACC_W-1:0] sum_u, sum_s;
    logic [N_CH-1:0]       ovf_u, ovf_s;
    logic [CNT_W-1:0]      count_u, count_s;

    int n_checks = 0;
    int n_fail   = 0;
    int m_cnt    = 0;
    int m_post   = 0;
    logic [IN_W-1:0]      q_act [$];
    logic [N_CH*WT_W-1:0] q_wt  [$];

    mac_array_accum #(.N_CH(N_CH), .IN_W(IN_W), .WT_W(WT_W), .ACC_W(ACC_W),
                      .DEPTH(DEPTH), .ACT_SGN(0)) u_dut (
        .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_u),
        .act_in(act_in), .wt_in(wt_in), .out_valid(out_valid_u), .out_ready(out_ready),
        .sum_out(sum_u), .ovf(ovf_u), .count(count_u));

    mac_array_accum #(.N_CH(N_CH), .IN_W(IN_W), .WT_W(WT_W), .ACC_W(ACC_W),
                      .DEPTH(DEPTH), .ACT_SGN(1)) u_dut_s (
        .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
        .act_in(act_in), .wt_in(wt_in), .out_valid(out_valid_s), .out_ready(out_ready),
        .sum_out(sum_s), .ovf(ovf_s), .count(count_s));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_cnt  = 0;
        m_post = 0;
        q_act.delete();
        q_wt.delete();
    endtask

    // Dot product of the queued samples with per-step saturation.
    task automatic model_result(input bit sgn, output logic [N_CH*ACC_W-1:0] s,
                                output logic [N_CH-1:0] o);
        longint maxv;
        longint minv;
        maxv = (longint'(1) << (ACC_W - 1)) - 1;
        minv = -(longint'(1) << (ACC_W - 1));
        s = '0;
        o = '0;
        for (int m = 0; m < N_CH; m++) begin
            longint acc;
            acc = 0;
            for (int k = 0; k < q_act.size(); k++) begin
                longint a;
                longint w;
                a = longint'(q_act[k]);
                if (sgn && q_act[k][IN_W-1]) a = a - (longint'(1) << IN_W);
                w = longint'(q_wt[k][m*WT_W +: WT_W]);
                if (w >= (longint'(1) << (WT_W - 1))) w = w - (longint'(1) << WT_W);
                acc = acc + a * w;
                if (acc > maxv) begin
                    acc = maxv;
                    o[m] = 1'b1;
                end else if (acc < minv) begin
                    acc = minv;
                    o[m] = 1'b1;
                end
            end
            s[m*ACC_W +: ACC_W] = acc[ACC_W-1:0];
        end
    endtask

    task automatic check_outputs();
        logic [N_CH*ACC_W-1:0] es;
        logic [N_CH-1:0]       eo;
        bit                    ev;
        ev = (m_cnt == DEPTH) && (m_post >= 1);
        check("in_ready", 64'(in_ready_u), 64'(m_cnt < DEPTH));
        check("in_ready_s", 64'(in_ready_s), 64'(m_cnt < DEPTH));
        check("out_valid", 64'(out_valid_u), 64'(ev));
        check("out_valid_s", 64'(out_valid_s), 64'(ev));
        check("count", 64'(count_u), 64'(m_cnt));
        check("count_s", 64'(count_s), 64'(m_cnt));
        if (ev) begin
            model_result(1'b0, es, eo);
            check("sum", 64'(sum_u), 64'(es));
            check("ovf", 64'(ovf_u), 64'(eo));
            model_result(1'b1, es, eo);
            check("sum_s", 64'(sum_s), 64'(es));
            check("ovf_s", 64'(ovf_s), 64'(eo));
        end
    endtask

    // One clock: update the model with the inputs seen at the edge, then compare.
    task automatic tick();
        @(posedge clk);
        if (flush) begin
            model_clear();
        end else if (m_cnt == DEPTH) begin
            if (m_post >= 1 && out_ready) model_clear();
            else m_post++;
        end else if (in_valid) begin
            q_act.push_back(act_in);
            q_wt.push_back(wt_in);
            m_cnt++;
        end
        #1;
        check_outputs();
    endtask

    task automatic send(input logic [IN_W-1:0] a, input logic [N_CH*WT_W-1:0] w,
                        input int gap);
        for (int i = 0; i < gap; i++) begin
            act_in = IN_W'($urandom);
            tick();
        end
        in_valid = 1'b1;
        act_in   = a;
        wt_in    = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 10 && !((m_cnt == DEPTH) && (m_post >= 1)); i++) tick();
    endtask

    // Hold DONE for 'hold' cycles with stray in_valid pulses, then handshake.
    task automatic take_result(input int hold);
        wait_valid();
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            act_in   = IN_W'($urandom);
            wt_in    = (N_CH*WT_W)'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        clr = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        act_in = '0; wt_in = '0;
        #2;
        check("rst_count", 64'(count_u), 64'd0);
        check("rst_out_valid", 64'(out_valid_u), 64'd0);
        check("rst_sum", 64'(sum_u), 64'd0);
        check("rst_ovf", 64'(ovf_u), 64'd0);
        #10 clr = 1'b1;
        #1 check("rst_in_ready", 64'(in_ready_u), 64'd1);

        // Basic dot product
        send(8'd10, {8'hFE, 8'h03}, 0);
        send(8'd20, {8'hFE, 8'h03}, 0);
        send(8'd30, {8'hFE, 8'h03}, 0);
        wait_valid();
        check("t1_sum", 64'(sum_u), 64'(32'hFF88_00B4));
        check("t1_ovf", 64'(ovf_u), 64'd0);
        take_result(1);

        // Saturation, then a clean follow-up
        for (int i = 0; i < 3; i++) send(8'd255, {8'h80, 8'h7F}, 0);
        wait_valid();
        check("t2_sum", 64'(sum_u), 64'(32'h8000_7FFF));
        check("t2_ovf", 64'(ovf_u), 64'd3);
        take_result(0);
        for (int i = 0; i < 3; i++) send(8'd1, {8'h01, 8'h01}, 0);
        wait_valid();
        check("t2b_sum", 64'(sum_u), 64'(32'h0003_0003));
        check("t2b_ovf", 64'(ovf_u), 64'd0);
        take_result(0);

        // Bubbles and backpressure
        send(8'd7, {8'h05, 8'hF9}, 0);
        send(8'd9, {8'h11, 8'h22}, 2);
        send(8'd200, {8'h80, 8'h7F}, 5);
        take_result(6);

        // Flush after two accepts; the sample offered with flush is dropped
        send(8'd50, {8'h40, 8'h40}, 0);
        send(8'd60, {8'h40, 8'h40}, 0);
        flush = 1'b1; in_valid = 1'b1; act_in = 8'd99;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("t4_count", 64'(count_u), 64'd0);
        check("t4_out_valid", 64'(out_valid_u), 64'd0);
        for (int i = 0; i < 3; i++) send(8'd1, {8'h01, 8'h01}, 0);
        wait_valid();
        check("t4_sum", 64'(sum_u), 64'(32'h0003_0003));
        take_result(0);

        // Async reset in DRAIN, between edges
        for (int i = 0; i < 3; i++) send(8'd100, {8'h7F, 8'h7F}, 0);
        #3 clr = 1'b0;
        #1;
        check("t5_out_valid", 64'(out_valid_u), 64'd0);
        check("t5_count", 64'(count_u), 64'd0);
        check("t5_sum", 64'(sum_u), 64'd0);
        model_clear();
        #1 clr = 1'b1;
        #1 check("t5_in_ready", 64'(in_ready_u), 64'd1);
        send(8'd10, {8'hFE, 8'h03}, 0);
        send(8'd20, {8'hFE, 8'h03}, 0);
        send(8'd30, {8'hFE, 8'h03}, 0);
        wait_valid();
        check("t5_sum_after", 64'(sum_u), 64'(32'hFF88_00B4));
        take_result(0);

        // Signed activations
        for (int i = 0; i < 3; i++) send(8'hFC, {8'hFD, 8'hFD}, 0);
        wait_valid();
        check("t6_sum_s", 64'(sum_s), 64'(32'h0024_0024));
        check("t6_ovf_s", 64'(ovf_s), 64'd0);
        take_result(0);

        // Randomized dot products with gaps, backpressure and occasional flush
        for (int r = 0; r < 40; r++) begin
            int n_before_flush;
            n_before_flush = (($urandom_range(0, 7) == 0) ? $urandom_range(0, DEPTH - 1) : DEPTH);
            for (int k = 0; k < DEPTH; k++) begin
                if (k == n_before_flush) begin
                    flush = 1'b1; in_valid = 1'($urandom_range(0, 1));
                    tick();
                    flush = 1'b0; in_valid = 1'b0;
                end
                send(IN_W'($urandom), (N_CH*WT_W)'($urandom), $urandom_range(0, 2));
            end
            take_result($urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
